cic_decim_iq: RTL

Dual-channel (I/Q) CIC decimator with a parametrised number of stages and a decimation ratio selectable at run time. Per channel, ORDER integrators run at the input sample rate. A single time-multiplexed comb engine processes both channels once per decimated sample. A run-time right shift with saturation scales the result to OUT_BITS, and the output is held under a valid/ready handshake with overrun detection. The block sits between the I/Q mixer and the AM demodulator.

---
 rtl/cic_pkg.sv | 34 +++
 rtl/cic_integ_chain.sv | 43 ++++
 rtl/cic_decim_iq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the dual-channel CIC decimator: sizing helpers,
// comb engine state encoding and output saturation.
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMB,
        SCALE,
        OUT
    } comb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Register growth of an N-stage CIC is N*log2(R*M) bits with M=1.
    function automatic int cic_width(input int bits, input int order, input int decim_max);
        return bits + order * clog2(decim_max);
    endfunction

    function automatic longint saturate(input longint value, input int out_bits);
        longint max_val;
        longint min_val;
        max_val = (longint'(1) <<< (out_bits - 1)) - 1;
        min_val = -max_val - 1;
        if (value > max_val) return max_val;
        if (value < min_val) return min_val;
        return value;
    endfunction

endpackage

// File: rtl/cic_integ_chain.sv
// Integrator cascade for one channel, running at the input sample rate, with a
// capture register holding the pre-update last-stage value at each wrap.
module cic_integ_chain
    import cic_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int ORDER = 3,
    parameter int WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_tick,
    input  logic                    capture,
    input  logic signed [BITS-1:0]  sample,
    output logic signed [WIDTH-1:0] captured
);

    logic signed [WIDTH-1:0] stage_reg [ORDER];
    logic signed [WIDTH-1:0] addend    [ORDER];

    // Wrap-around arithmetic is intentional: the combs undo the overflow.
    genvar gi;
    for (gi = 0; gi < ORDER; gi++) begin : g_addend
        if (gi == 0) begin : g_input
            assign addend[gi] = WIDTH'(sample);
        end else begin : g_cascade
            assign addend[gi] = stage_reg[gi-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < ORDER; k++) stage_reg[k] <= '0;
            captured <= '0;
        end else begin
            if (in_tick) begin
                for (int k = 0; k < ORDER; k++) stage_reg[k] <= stage_reg[k] + addend[k];
            end
            if (capture) captured <= stage_reg[ORDER-1];
        end
    end

endmodule

// File: rtl/cic_decim_iq.sv
// Dual-channel CIC decimator: per-channel integrators, one time-shared comb
// engine, run-time shift with saturation and a valid/ready output stage.
module cic_decim_iq
    import cic_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int ORDER      = 3,
    parameter int DECIM_MAX  = 256,
    parameter int CNT_BITS   = 8,
    parameter int OUT_BITS   = 16,
    parameter int SHIFT_BITS = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_tick,
    input  logic signed [BITS-1:0]     i_in,
    input  logic signed [BITS-1:0]     q_in,
    input  logic [CNT_BITS-1:0]        decim,
    input  logic [SHIFT_BITS-1:0]      shift,
    output logic signed [OUT_BITS-1:0] i_out,
    output logic signed [OUT_BITS-1:0] q_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    output logic                       busy
);

    localparam int WIDTH     = cic_width(BITS, ORDER, DECIM_MAX);
    localparam int STEPS     = 2 * ORDER;
    localparam int STEP_BITS = clog2(STEPS);
    localparam int WARM_BITS = clog2(ORDER + 1);

    comb_state_t                 state_reg;
    logic [CNT_BITS-1:0]         phase_reg;
    logic [CNT_BITS-1:0]         ratio_reg;
    logic [CNT_BITS-1:0]         ratio_next;
    logic [STEP_BITS-1:0]        step_reg;
    logic [WARM_BITS-1:0]        warm_reg;
    logic signed [WIDTH-1:0]     cap_i;
    logic signed [WIDTH-1:0]     cap_q;
    logic signed [WIDTH-1:0]     x_reg;
    logic signed [WIDTH-1:0]     comb_i_reg;
    logic signed [WIDTH-1:0]     x_cur;
    logic signed [WIDTH-1:0]     y_cur;
    logic signed [WIDTH-1:0]     shifted_i;
    logic signed [WIDTH-1:0]     shifted_q;
    logic signed [WIDTH-1:0]     delay_reg [STEPS];
    logic signed [OUT_BITS-1:0]  scaled_i_reg;
    logic signed [OUT_BITS-1:0]  scaled_q_reg;
    logic                        wrap;
    logic                        capture;
    logic                        ratio_change;

    // ratio_reg holds R-1; a requested R of 1 is promoted to 2.
    assign ratio_next   = (decim == '0) ? CNT_BITS'(1) : decim;
    assign wrap         = in_tick && (phase_reg == ratio_reg);
    assign busy         = (state_reg != IDLE);
    assign capture      = wrap && !busy;
    assign ratio_change = wrap && (ratio_next != ratio_reg);

    // Step 0 and step ORDER start a channel from its captured integrator value.
    assign x_cur = (step_reg == '0)                  ? cap_i :
                   (step_reg == STEP_BITS'(ORDER))   ? cap_q : x_reg;
    assign y_cur     = x_cur - delay_reg[step_reg];
    assign shifted_i = comb_i_reg >>> shift;
    assign shifted_q = x_reg >>> shift;

    cic_integ_chain #(.BITS(BITS), .ORDER(ORDER), .WIDTH(WIDTH)) u_integ_i (
        .CLK      (CLK),
        .RST      (RST),
        .in_tick  (in_tick),
        .capture  (capture),
        .sample   (i_in),
        .captured (cap_i)
    );

    cic_integ_chain #(.BITS(BITS), .ORDER(ORDER), .WIDTH(WIDTH)) u_integ_q (
        .CLK      (CLK),
        .RST      (RST),
        .in_tick  (in_tick),
        .capture  (capture),
        .sample   (q_in),
        .captured (cap_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            ratio_reg    <= ratio_next;
            step_reg     <= '0;
            warm_reg     <= WARM_BITS'(ORDER);
            x_reg        <= '0;
            comb_i_reg   <= '0;
            scaled_i_reg <= '0;
            scaled_q_reg <= '0;
            i_out        <= '0;
            q_out        <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            for (int k = 0; k < STEPS; k++) delay_reg[k] <= '0;
        end else begin
            if (in_tick) phase_reg <= wrap ? '0 : phase_reg + CNT_BITS'(1);
            if (wrap) ratio_reg <= ratio_next;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (wrap && busy) overrun <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (wrap) begin
                        state_reg <= COMB;
                        step_reg  <= '0;
                    end
                end
                COMB: begin
                    delay_reg[step_reg] <= x_cur;
                    x_reg               <= y_cur;
                    if (step_reg == STEP_BITS'(ORDER - 1)) comb_i_reg <= y_cur;
                    if (step_reg == STEP_BITS'(STEPS - 1)) state_reg <= SCALE;
                    else step_reg <= step_reg + STEP_BITS'(1);
                end
                SCALE: begin
                    scaled_i_reg <= OUT_BITS'(saturate(longint'(shifted_i), OUT_BITS));
                    scaled_q_reg <= OUT_BITS'(saturate(longint'(shifted_q), OUT_BITS));
                    state_reg    <= OUT;
                end
                OUT: begin
                    state_reg <= IDLE;
                    if (warm_reg != '0) begin
                        warm_reg <= warm_reg - WARM_BITS'(1);
                    end else begin
                        i_out     <= scaled_i_reg;
                        q_out     <= scaled_q_reg;
                        out_valid <= 1'b1;
                        if (out_valid && !out_ready) overrun <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // New ratio: comb history from the old rate is meaningless.
            if (ratio_change) begin
                for (int k = 0; k < STEPS; k++) delay_reg[k] <= '0;
                warm_reg <= WARM_BITS'(ORDER);
            end
        end
    end

endmodule
